// File: rtl/rco_captura.sv
// Event capture stage for contador16bits: snapshots Q with a mask of rising
// carries on each RCO edge and buffers the records in a small FWFT FIFO.
module rco_captura #(
  parameter int DEPTH = 4,
  parameter int DROPW = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enb,
  input  logic [15:0]              Q,
  input  logic [3:0]               RCO,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [19:0]              rd_data,
  output logic [$clog2(DEPTH):0]   nivel,
  output logic [15:0]              evt_cnt,
  output logic [DROPW-1:0]         drop_cnt,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [19:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [3:0]    rco_prev;
  logic [3:0]    rise;
  logic          evt;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  assign rise = RCO & ~rco_prev;
  assign evt  = enb & (|rise);
  assign full = (nivel == FULL_LVL);
  assign pop  = rd_valid & rd_ready;
  // A full FIFO still accepts a record when the head leaves in the same cycle.
  assign push = evt & (~full | pop);
  assign drop = evt & full & ~pop;

  assign rd_valid = (nivel != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr] : 20'h0;

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= {rise, Q};
    end
  end

  // Loading rco_prev from RCO during reset masks carries already high at release.
  always_ff @(posedge clk) begin
    if (reset) begin
      rco_prev <= RCO;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      nivel    <= '0;
      evt_cnt  <= '0;
      drop_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      rco_prev <= RCO;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        nivel <= nivel + (AW+1)'(1);
      end else if (pop && !push) begin
        nivel <= nivel - (AW+1)'(1);
      end
      if (evt) begin
        evt_cnt <= evt_cnt + 16'd1;
      end
      if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != '1) begin
          drop_cnt <= drop_cnt + DROPW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rco_captura.sv
// Directed self-checking bench for rco_captura: reset masking, capture,
// overflow, full-with-pop, enable gating, drop saturation and mid-run reset.
module tb_rco_captura;

  logic        clk = 1'b0;
  logic        reset;
  logic        enb;
  logic [15:0] Q;
  logic [3:0]  RCO;
  logic        rd_ready;
  logic        rd_valid;
  logic [19:0] rd_data;
  logic [2:0]  nivel;
  logic [15:0] evt_cnt;
  logic [7:0]  drop_cnt;
  logic        ovf;

  int checks = 0;
  int fails  = 0;

  rco_captura #(.DEPTH(4), .DROPW(8)) dut (
    .clk(clk), .reset(reset), .enb(enb), .Q(Q), .RCO(RCO),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .nivel(nivel), .evt_cnt(evt_cnt), .drop_cnt(drop_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; RCO = 4'b0000; rd_ready = 1'b0; enb = 1'b1; Q = 16'h0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] mask, input logic [15:0] q);
    RCO = mask; Q = q;
    tick();
    RCO = 4'b0000;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; enb = 1'b1; Q = 16'h1234; RCO = 4'b0001; rd_ready = 1'b0;
    tick();
    tick();
    checks++; if (rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %0b expected 0", rd_valid); end
    checks++; if (rd_data !== 20'h0) begin fails++; $display("[TB] FAIL reset_data: got %h expected 00000", rd_data); end
    checks++; if (nivel !== 3'd0) begin fails++; $display("[TB] FAIL reset_nivel: got %0d expected 0", nivel); end
    checks++; if (drop_cnt !== 8'd0 || ovf !== 1'b0) begin fails++; $display("[TB] FAIL reset_drop: got drop=%0d ovf=%0b expected 0/0", drop_cnt, ovf); end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (evt_cnt !== 16'd0) begin fails++; $display("[TB] FAIL reset_rco_high_evt: got %0d expected 0", evt_cnt); end
    checks++; if (rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rco_high_valid: got %0b expected 0", rd_valid); end
  endtask

  task automatic test_single_capture();
    RCO = 4'b0000;
    tick();
    enb = 1'b1; Q = 16'h00FF; RCO = 4'b0011; rd_ready = 1'b0;
    tick();
    checks++; if (rd_valid !== 1'b1) begin fails++; $display("[TB] FAIL single_valid: got %0b expected 1", rd_valid); end
    checks++; if (rd_data !== 20'h300FF) begin fails++; $display("[TB] FAIL single_data: got %h expected 300ff", rd_data); end
    checks++; if (nivel !== 3'd1) begin fails++; $display("[TB] FAIL single_nivel: got %0d expected 1", nivel); end
    checks++; if (evt_cnt !== 16'd1) begin fails++; $display("[TB] FAIL single_evt: got %0d expected 1", evt_cnt); end
    RCO = 4'b0000; Q = 16'h0100;
    tick();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    checks++; if (rd_valid !== 1'b0 || nivel !== 3'd0) begin fails++; $display("[TB] FAIL single_drain: got valid=%0b nivel=%0d expected 0/0", rd_valid, nivel); end
    checks++; if (rd_data !== 20'h0) begin fails++; $display("[TB] FAIL single_gated: got %h expected 00000", rd_data); end
  endtask

  task automatic test_fill_overflow();
    logic [3:0] masks [5];
    masks = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    do_reset();
    for (int i = 0; i < 5; i++) pulse(masks[i], 16'h1000 + 16'(i));
    checks++; if (nivel !== 3'd4) begin fails++; $display("[TB] FAIL fill_nivel: got %0d expected 4", nivel); end
    checks++; if (drop_cnt !== 8'd1) begin fails++; $display("[TB] FAIL fill_drop: got %0d expected 1", drop_cnt); end
    checks++; if (ovf !== 1'b1) begin fails++; $display("[TB] FAIL fill_ovf: got %0b expected 1", ovf); end
    checks++; if (evt_cnt !== 16'd5) begin fails++; $display("[TB] FAIL fill_evt: got %0d expected 5", evt_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data !== {masks[i], 16'h1000 + 16'(i)}) begin
        fails++; $display("[TB] FAIL fill_order[%0d]: got %h expected %h", i, rd_data, {masks[i], 16'h1000 + 16'(i)});
      end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
    checks++; if (rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL fill_empty: got %0b expected 0", rd_valid); end
    checks++; if (ovf !== 1'b1) begin fails++; $display("[TB] FAIL fill_ovf_sticky: got %0b expected 1", ovf); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    pulse(4'h2, 16'h0AAA);
    RCO = 4'h4; Q = 16'h0BBB; rd_ready = 1'b1;
    tick();
    RCO = 4'h0; rd_ready = 1'b0;
    checks++; if (nivel !== 3'd1) begin fails++; $display("[TB] FAIL b2b_nivel: got %0d expected 1", nivel); end
    checks++; if (rd_data !== 20'h40BBB) begin fails++; $display("[TB] FAIL b2b_head: got %h expected 40bbb", rd_data); end
    checks++; if (evt_cnt !== 16'd2) begin fails++; $display("[TB] FAIL b2b_evt: got %0d expected 2", evt_cnt); end
  endtask

  task automatic test_full_pop();
    logic [19:0] exp [4];
    exp = '{20'h22001, 20'h42002, 20'h82003, 20'hF2ABC};
    do_reset();
    pulse(4'h1, 16'h2000);
    pulse(4'h2, 16'h2001);
    pulse(4'h4, 16'h2002);
    pulse(4'h8, 16'h2003);
    RCO = 4'hF; Q = 16'h2ABC; rd_ready = 1'b1;
    tick();
    RCO = 4'h0; rd_ready = 1'b0;
    checks++; if (nivel !== 3'd4) begin fails++; $display("[TB] FAIL fullpop_nivel: got %0d expected 4", nivel); end
    checks++; if (drop_cnt !== 8'd0 || ovf !== 1'b0) begin fails++; $display("[TB] FAIL fullpop_nodrop: got drop=%0d ovf=%0b expected 0/0", drop_cnt, ovf); end
    checks++; if (evt_cnt !== 16'd5) begin fails++; $display("[TB] FAIL fullpop_evt: got %0d expected 5", evt_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data !== exp[i]) begin
        fails++; $display("[TB] FAIL fullpop_order[%0d]: got %h expected %h", i, rd_data, exp[i]);
      end
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
    end
    checks++; if (nivel !== 3'd0) begin fails++; $display("[TB] FAIL fullpop_empty: got %0d expected 0", nivel); end
  endtask

  task automatic test_enable_saturation();
    do_reset();
    enb = 1'b0; RCO = 4'b0001; Q = 16'h5555;
    tick();
    enb = 1'b1;
    tick();
    tick();
    checks++; if (evt_cnt !== 16'd0 || rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL enb_gate: got evt=%0d valid=%0b expected 0/0", evt_cnt, rd_valid); end
    RCO = 4'b0000;
    tick();
    for (int i = 0; i < 4; i++) pulse(4'h8, 16'(i));
    checks++; if (drop_cnt !== 8'd0 || nivel !== 3'd4) begin fails++; $display("[TB] FAIL sat_fill: got drop=%0d nivel=%0d expected 0/4", drop_cnt, nivel); end
    for (int i = 4; i < 300; i++) pulse(4'h8, 16'(i));
    checks++; if (drop_cnt !== 8'd255) begin fails++; $display("[TB] FAIL sat_drop: got %0d expected 255", drop_cnt); end
    checks++; if (evt_cnt !== 16'd300) begin fails++; $display("[TB] FAIL sat_evt: got %0d expected 300", evt_cnt); end
    checks++; if (ovf !== 1'b1 || nivel !== 3'd4) begin fails++; $display("[TB] FAIL sat_state: got ovf=%0b nivel=%0d expected 1/4", ovf, nivel); end
    checks++; if (rd_data !== 20'h80000) begin fails++; $display("[TB] FAIL sat_head: got %h expected 80000", rd_data); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    pulse(4'h1, 16'h3000);
    pulse(4'h2, 16'h3001);
    pulse(4'h4, 16'h3002);
    reset = 1'b1; RCO = 4'b0100; Q = 16'h3003; rd_ready = 1'b1;
    tick();
    reset = 1'b0; rd_ready = 1'b0;
    checks++; if (rd_valid !== 1'b0 || nivel !== 3'd0) begin fails++; $display("[TB] FAIL midrst_empty: got valid=%0b nivel=%0d expected 0/0", rd_valid, nivel); end
    checks++; if (rd_data !== 20'h0) begin fails++; $display("[TB] FAIL midrst_data: got %h expected 00000", rd_data); end
    checks++; if (evt_cnt !== 16'd0 || drop_cnt !== 8'd0 || ovf !== 1'b0) begin fails++; $display("[TB] FAIL midrst_stats: got evt=%0d drop=%0d ovf=%0b expected 0/0/0", evt_cnt, drop_cnt, ovf); end
    tick();
    checks++; if (evt_cnt !== 16'd0 || rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL midrst_rco_high: got evt=%0d valid=%0b expected 0/0", evt_cnt, rd_valid); end
  endtask

  initial begin
    test_reset();
    test_single_capture();
    test_fill_overflow();
    test_back_to_back();
    test_full_pop();
    test_enable_saturation();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
